// File: rtl/sensor_humedad_pkg.sv
// Shared definitions for the soil-moisture front end.
// Holds the default clock rate, helpers that derive the cycle counts
// (sample period P and lockout length), the lockout FSM encoding and
// the probe polarity.
package sensor_humedad_pkg;

  localparam int unsigned CLK_HZ_DEF = 50_000_000;

  // Sample period in clock cycles: P = CLK_HZ/1000*MUESTRA_MS.
  function automatic int unsigned ciclos_muestra(input int unsigned clk_hz,
                                                 input int unsigned ms);
    return clk_hz / 1000 * ms;
  endfunction

  // Lockout length in clock cycles, on the pump's 36-bit timebase.
  function automatic logic [35:0] ciclos_bloqueo(input int unsigned clk_hz,
                                                 input int unsigned seg);
    return 36'(clk_hz) * 36'(seg);
  endfunction

  localparam int unsigned P_DEF       = ciclos_muestra(CLK_HZ_DEF, 100);
  localparam logic [35:0] BLOQUEO_DEF = ciclos_bloqueo(CLK_HZ_DEF, 20);

  typedef enum logic [1:0] {
    LIBRE   = 2'd0,
    BOMBEO  = 2'd1,
    BLOQUEO = 2'd2
  } estado_t;

  // Comparator output level meaning "dry soil".
  localparam logic SECO = 1'b1;

endpackage

// File: rtl/sensor_humedad_generador_tic.sv
// Free-running prescaler producing a one-cycle tick every PERIODO cycles.
// Ports:
//   i_clk   - clock
//   i_rst_n - asynchronous active-low reset
//   o_tic   - high for one cycle when the count reaches PERIODO-1
module generador_tic #(
  parameter int unsigned PERIODO = 10
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tic
);

  localparam int unsigned ANCHO = (PERIODO > 1) ? $clog2(PERIODO) : 1;
  localparam logic [ANCHO-1:0] ULTIMO = ANCHO'(PERIODO - 1);

  logic [ANCHO-1:0] r_cuenta;

  assign o_tic = (r_cuenta == ULTIMO);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cuenta <= '0;
    end else if (o_tic) begin
      r_cuenta <= '0;
    end else begin
      r_cuenta <= r_cuenta + ANCHO'(1);
    end
  end

endmodule

// File: rtl/sensor_humedad.sv
// Soil-moisture front end: synchronizes the probe comparator, counts dry
// samples over a window of VENTANA ticks, applies hysteresis to produce the
// irrigation request, and suppresses the request while the pump runs and
// during a soak-in lockout after each pump cycle.
// Ports:
//   clk            - system clock
//   rst_n          - asynchronous active-low reset
//   sensor_raw     - asynchronous probe comparator output (1 = dry)
//   bomba_n        - pump status, synchronous, active-low (0 = pump on)
//   activar        - registered irrigation request
//   muestra_valida - one-cycle pulse after each completed window
//   conteo_seco    - dry-sample count of the last completed window
//   bloqueado      - registered "pump running or in lockout"
module sensor_humedad
  import sensor_humedad_pkg::*;
#(
  parameter int unsigned CLK_HZ     = CLK_HZ_DEF,
  parameter int unsigned MUESTRA_MS = 100,
  parameter int unsigned VENTANA    = 8,
  parameter int unsigned UMBRAL_ON  = 6,
  parameter int unsigned UMBRAL_OFF = 2,
  parameter int unsigned BLOQUEO_S  = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sensor_raw,
  input  logic       bomba_n,
  output logic       activar,
  output logic       muestra_valida,
  output logic [3:0] conteo_seco,
  output logic       bloqueado
);

  localparam int unsigned P           = ciclos_muestra(CLK_HZ, MUESTRA_MS);
  localparam logic [35:0] FIN_BLOQUEO = ciclos_bloqueo(CLK_HZ, BLOQUEO_S) - 36'd1;
  localparam logic [3:0]  ULT_MUESTRA = 4'(VENTANA - 1);
  localparam logic [3:0]  UMB_ON      = 4'(UMBRAL_ON);
  localparam logic [3:0]  UMB_OFF     = 4'(UMBRAL_OFF);

  logic        r_sync1;
  logic        r_s_sync;
  logic        w_tic;
  logic        w_seco;
  logic [3:0]  w_suma;
  logic [3:0]  r_acum;
  logic [3:0]  r_indice;
  logic        r_fin;
  estado_t     r_estado;
  estado_t     w_estado_sig;
  logic [35:0] r_cnt_bloq;
  logic [35:0] w_cnt_sig;

  // Two-flop synchronizer for the asynchronous probe output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= 1'b0;
      r_s_sync <= 1'b0;
    end else begin
      r_sync1  <= sensor_raw;
      r_s_sync <= r_sync1;
    end
  end

  generador_tic #(
    .PERIODO(P)
  ) u_tic (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .o_tic  (w_tic)
  );

  assign w_seco = (r_s_sync == SECO);
  assign w_suma = r_acum + {3'b000, w_seco};

  // Window accumulation. r_fin marks the window-complete cycle, one cycle
  // after the closing tick, so hysteresis sees the freshly loaded count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acum      <= '0;
      r_indice    <= '0;
      conteo_seco <= '0;
      r_fin       <= 1'b0;
    end else begin
      r_fin <= 1'b0;
      if (w_tic) begin
        if (r_indice == ULT_MUESTRA) begin
          conteo_seco <= w_suma;
          r_acum      <= '0;
          r_indice    <= '0;
          r_fin       <= 1'b1;
        end else begin
          r_acum   <= w_suma;
          r_indice <= r_indice + 4'd1;
        end
      end
    end
  end

  // Lockout FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado   <= LIBRE;
      r_cnt_bloq <= '0;
    end else begin
      r_estado   <= w_estado_sig;
      r_cnt_bloq <= w_cnt_sig;
    end
  end

  // The lockout counter only runs in BLOQUEO; every other state holds it
  // at zero, which also clears it on the BOMBEO -> BLOQUEO transition.
  always_comb begin
    w_estado_sig = r_estado;
    w_cnt_sig    = '0;
    case (r_estado)
      LIBRE: begin
        if (!bomba_n) w_estado_sig = BOMBEO;
      end
      BOMBEO: begin
        if (bomba_n) w_estado_sig = BLOQUEO;
      end
      BLOQUEO: begin
        if (!bomba_n) begin
          w_estado_sig = BOMBEO;
        end else if (r_cnt_bloq == FIN_BLOQUEO) begin
          w_estado_sig = LIBRE;
        end else begin
          w_cnt_sig = r_cnt_bloq + 36'd1;
        end
      end
      default: w_estado_sig = LIBRE;
    endcase
  end

  // Output register. Suppression takes priority over hysteresis; a window
  // that completes while the FSM is leaving LIBRE may not raise the request,
  // so the pump-on edge never produces a one-cycle activar glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      activar        <= 1'b0;
      muestra_valida <= 1'b0;
      bloqueado      <= 1'b0;
    end else begin
      muestra_valida <= r_fin;
      bloqueado      <= (r_estado != LIBRE);
      if (r_estado != LIBRE) begin
        activar <= 1'b0;
      end else if (r_fin) begin
        if ((conteo_seco >= UMB_ON) && (w_estado_sig == LIBRE)) begin
          activar <= 1'b1;
        end else if (conteo_seco <= UMB_OFF) begin
          activar <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/sensor_humedad.md
# sensor_humedad

Soil-moisture front end for the irrigation controller: samples the raw digital output of the moisture probe comparator and filters it over a sample window with hysteresis. It produces the `activar` request consumed by the pump controller `bomba`. It also watches the pump's active-low status line (`bomba_n`) and suppresses requests while the pump runs and during a soak-in lockout after each pump cycle.

## Interface
- `CLK_HZ`, 50_000_000: clock frequency in Hz.
- `MUESTRA_MS`, 100: sample period in ms; P = CLK_HZ/1000*MUESTRA_MS cycles.
- `VENTANA`, 8: samples per window, 2..15.
- `UMBRAL_ON`, 6: dry count per window that is ≥ this sets the request.
- `UMBRAL_OFF`, 2: dry count per window that is ≤ this clears the request. UMBRAL_OFF < UMBRAL_ON ≤ VENTANA.
- `BLOQUEO_S`, 20: lockout after pump switches off, in seconds.
- `clk` in 1: system clock, 50 MHz.
- `rst_n` in 1: asynchronous, active-low reset.
- `sensor_raw` in 1: probe comparator output, asynchronous; 1 = dry.
- `bomba_n` in 1: pump status from `bomba`, synchronous to `clk`; 0 = pump on.
- `activar` out 1: registered irrigation request; 1 = water needed.
- `muestra_valida` out 1: one-cycle pulse when a window completes.
- `conteo_seco` out 4: dry-sample count of the last completed window.
- `bloqueado` out 1: 1 while in BOMBEO or BLOQUEO.

## Operation
- Reset (async assert): `activar`=0, `muestra_valida`=0, `conteo_seco`=0, `bloqueado`=0. All counters and synchronizer flops are 0. FSM = LIBRE.
- Synchronization: `sensor_raw` passes through a 2-flop synchronizer. Only the synchronized value `s_sync` is used.
- Tick generation: the prescaler counts 0..P-1. `tic` is high for one cycle when the count = P-1, then the count wraps to 0. The prescaler free-runs and is never gated.
- Sampling on `tic`:
  - The accumulator adds `s_sync` and the sample index increments.
  - On the VENTANA-th sample, `conteo_seco` is loaded with the accumulator value including this sample.
  - On the cycle after that tick, `muestra_valida` pulses.
  - The accumulator and index then restart at 0.
- Hysteresis, evaluated on the window-complete cycle, with c = the new count:
  - c ≥ UMBRAL_ON and FSM = LIBRE → `activar`=1.
  - c ≤ UMBRAL_OFF → `activar`=0.
  - Otherwise `activar` holds its value.
- Lockout FSM:
  - LIBRE: `bomba_n`=0 → BOMBEO.
  - BOMBEO: `bomba_n`=1 → BLOQUEO, with the lockout counter cleared.
  - BLOQUEO: `bomba_n`=0 → BOMBEO. Otherwise the counter reaches BLOQUEO_S*CLK_HZ-1 → LIBRE.
- Outputs in BOMBEO or BLOQUEO:
  - `activar` is forced to 0 on the cycle after the FSM enters that state.
  - `activar` stays 0 while the FSM remains there.
  - Window results are still computed and reported.
- `bloqueado` is the registered decode of state ≠ LIBRE.
- Simultaneous events: if a window completes on the same cycle as the BOMBEO entry, the force-to-0 wins.
- Window continuity: window accumulation continues across FSM transitions. No window is discarded.
- Return to LIBRE: `activar` stays 0 until the next window-complete with c ≥ UMBRAL_ON.
- Reset mid-window: partial accumulation is lost. The first window after reset starts at the first `tic` after release.

## Timing
- Sensor path: synchronizer latency is 2 cycles from a `sensor_raw` edge to `s_sync`.
- First `tic` after reset release occurs at cycle P. The first `muestra_valida` occurs at cycle VENTANA*P+1.
- `activar` and `muestra_valida` change on the same clock edge.
- `bomba_n` falling edge → `bloqueado`=1 and `activar`=0 two edges later (FSM register, then output register).
- Lockout length: from the `bomba_n` rising edge to `bloqueado`=0 is BLOQUEO_S*CLK_HZ+2 cycles.
- Widths:
  - Lockout counter: 36 bits, matching the pump's 36-bit timebase; 1e9 for the defaults.
  - Prescaler: ⌈log2 P⌉ bits.
  - Accumulator and `conteo_seco`: 4 bits, which can hold up to 15.
  - Compares are unsigned.

## Structure
- Shared package holds:
  - the CLK_HZ constant and the derived cycle counts P and BLOQUEO_S*CLK_HZ;
  - the FSM state encoding: LIBRE=2'd0, BOMBEO=2'd1, BLOQUEO=2'd2;
  - the sensor polarity constant SECO=1'b1.
- One sub-module, `generador_tic`, is parameterized by period and outputs the one-cycle `tic`. It is reused for the prescaler.
- Synchronizer, accumulator, hysteresis and FSM stay inline.

## Test plan
Sim parameters: CLK_HZ=10_000, MUESTRA_MS=1 (P=10), VENTANA=8, UMBRAL_ON=6, UMBRAL_OFF=2, BLOQUEO_S=1 (10_000 cycles).
- Reset release with `sensor_raw`=1 constant and `bomba_n`=1:
  - `muestra_valida` pulses at cycle 81;
  - `conteo_seco`=8 and `activar`=1 on that edge.
- Hold band: after `activar`=1, drive 4 dry / 4 wet per window → `conteo_seco`=4, `activar` stays 1. Then 1 dry per window → `activar`=0 at that window's end.
- Run suppression: with `activar`=1, drop `bomba_n` to 0 → `bloqueado`=1 and `activar`=0 two cycles later. Windows of 8 dry during BOMBEO keep `activar`=0.
- Lockout duration: raise `bomba_n` → `bloqueado` falls exactly 10_002 cycles later. The next all-dry window then sets `activar`=1.
- Simultaneous event: a window completes with count 8 on the same cycle the FSM enters BOMBEO → `activar` stays 0.
- Async reset mid-window with 5 samples accumulated, asserted between clock edges → all outputs 0 immediately. The next window counts only post-reset samples.
